// File: rtl/adder_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : adder_arb_defs (package)
// Purpose  : Shared widths, FSM state encoding and grant helper for the
//            two-requester adder arbiter.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package adder_arb_defs;

  localparam int OP_W  = 5;  // operand width
  localparam int SUM_W = 6;  // result width: {cout, sum[4:0]}

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Winner among the two requesters: a lone requester always wins, a tie
  // is broken by the round-robin pointer. Returns the requester index.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic ptr);
    return (v0 && v1) ? ptr : v1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : adder_arbiter_if
// Purpose  : Requester, response and status signals of the adder arbiter.
//            slave = arbiter side, master = requester/consumer side.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface adder_arbiter_if;
  import adder_arb_defs::*;

  logic             req0_valid;
  logic [OP_W-1:0]  req0_x;
  logic [OP_W-1:0]  req0_y;
  logic             req0_ready;

  logic             req1_valid;
  logic [OP_W-1:0]  req1_x;
  logic [OP_W-1:0]  req1_y;
  logic             req1_ready;

  logic             resp_valid;
  logic             resp_ready;
  logic [SUM_W-1:0] resp_sum;
  logic             resp_id;

  logic             busy;

  modport slave (
    input  req0_valid, req0_x, req0_y,
    output req0_ready,
    input  req1_valid, req1_x, req1_y,
    output req1_ready,
    output resp_valid, resp_sum, resp_id,
    input  resp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_x, req0_y,
    input  req0_ready,
    output req1_valid, req1_x, req1_y,
    input  req1_ready,
    input  resp_valid, resp_sum, resp_id,
    output resp_ready,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/adder_arbiter_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : five_bit_adder
// Purpose  : Unsigned 5-bit adder with carry out. Purely combinational.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module five_bit_adder (
  input  wire logic [4:0] i_a,
  input  wire logic [4:0] i_b,
  output logic      [4:0] o_z,
  output logic            o_cout
);

  // Zero-extend both operands so the carry lands in the top bit.
  assign {o_cout, o_z} = {1'b0, i_a} + {1'b0, i_b};

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : adder_arbiter
// Purpose  : Round-robin arbiter between two operand requesters feeding a
//            single registered 5-bit adder. One operation in flight at a
//            time: IDLE (accept) -> CALC (add) -> HOLD (present result).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module adder_arbiter
  import adder_arb_defs::*;
(
  input  wire logic  clk,
  input  wire logic  rst,
  adder_arbiter_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic             r_id;
  logic [OP_W-1:0]  r_x;
  logic [OP_W-1:0]  r_y;
  logic [SUM_W-1:0] r_sum;

  logic             w_grant;
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_accept;
  logic             w_resp_valid;
  logic             w_resp_fire;
  logic [OP_W-1:0]  w_z;
  logic             w_cout;

  // Arbitration winner for the current cycle; only used while idle.
  always_comb begin
    w_grant = pick_grant(bus.req0_valid, bus.req1_valid, r_ptr);
  end

  // Next-state and handshake decode. Ready is withheld during reset so
  // nothing can be accepted while the block is being cleared.
  always_comb begin
    w_state_nxt  = r_state;
    w_rdy0       = 1'b0;
    w_rdy1       = 1'b0;
    w_accept     = 1'b0;
    w_resp_valid = 1'b0;
    w_resp_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rst) begin
          w_rdy0   = bus.req0_valid && !w_grant;
          w_rdy1   = bus.req1_valid &&  w_grant;
          w_accept = w_rdy0 || w_rdy1;
        end
        if (w_accept) begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) begin
          w_resp_fire = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the winning requester's operands and identity on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_id <= 1'b0;
    end else if (w_accept) begin
      r_x  <= w_grant ? bus.req1_x : bus.req0_x;
      r_y  <= w_grant ? bus.req1_y : bus.req0_y;
      r_id <= w_grant;
    end
  end

  // The single adder sees only the operand registers.
  five_bit_adder u_adder (
    .i_a    (r_x),
    .i_b    (r_y),
    .o_z    (w_z),
    .o_cout (w_cout)
  );

  // Register the sum in CALC; it then stays put through HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (r_state == ST_CALC) begin
      r_sum <= {w_cout, w_z};
    end
  end

  // Round-robin pointer moves only when a result is consumed, and then
  // favours the requester that was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_resp_fire) begin
      r_ptr <= ~r_id;
    end
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_sum   = r_sum;
  assign bus.resp_id    = r_id;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_adder_arbiter
// Purpose  : Self-checking bench for adder_arbiter: directed scenarios with
//            literal expectations plus randomized traffic against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_adder_arbiter;
  import adder_arb_defs::*;

  logic clk = 1'b0;
  logic rst;

  adder_arbiter_if bus_if ();

  adder_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding operation at most; it was accepted on cycle m_acc and
  // its result is presented from cycle m_acc+2 until consumed.
  bit m_pend = 0;
  int m_acc  = 0;
  int m_cyc  = 0;
  int m_sum  = 0;
  bit m_id   = 0;
  bit m_ptr  = 0;
  int e_rv, e_r0, e_r1, g;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready0", bus_if.req0_ready, 0);
      chk("rst_ready1", bus_if.req1_ready, 0);
      chk("rst_resp_valid", bus_if.resp_valid, 0);
      chk("rst_resp_sum", bus_if.resp_sum, 0);
      chk("rst_resp_id", bus_if.resp_id, 0);
      chk("rst_busy", bus_if.busy, 0);
      m_pend = 0;
      m_ptr  = 0;
    end else begin
      e_rv = (m_pend && (m_cyc >= m_acc + 2)) ? 1 : 0;
      g    = 0;
      e_r0 = 0;
      e_r1 = 0;
      if (!m_pend) begin
        if (bus_if.req0_valid && bus_if.req1_valid) g = m_ptr;
        else g = bus_if.req1_valid ? 1 : 0;
        e_r0 = (bus_if.req0_valid && g == 0) ? 1 : 0;
        e_r1 = (bus_if.req1_valid && g == 1) ? 1 : 0;
      end
      chk("model_ready0", bus_if.req0_ready, e_r0);
      chk("model_ready1", bus_if.req1_ready, e_r1);
      chk("model_resp_valid", bus_if.resp_valid, e_rv);
      chk("model_busy", bus_if.busy, m_pend ? 1 : 0);
      if (e_rv != 0) begin
        chk("model_resp_sum", bus_if.resp_sum, m_sum);
        chk("model_resp_id", bus_if.resp_id, m_id);
      end
      if (!m_pend && (bus_if.req0_valid || bus_if.req1_valid)) begin
        m_pend = 1;
        m_acc  = m_cyc;
        m_id   = g[0];
        m_sum  = (g == 1) ? int'(bus_if.req1_x) + int'(bus_if.req1_y)
                          : int'(bus_if.req0_x) + int'(bus_if.req0_y);
      end else if (e_rv != 0 && bus_if.resp_ready) begin
        m_pend = 0;
        m_ptr  = !m_id;
      end
    end
    m_cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    bus_if.req0_x = '0; bus_if.req0_y = '0;
    bus_if.req1_x = '0; bus_if.req1_y = '0;
    bus_if.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rv(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus_if.resp_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit saw;
    int k;
    int ids[4];
    int sums[4];

    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Single requester 3+4: ready now, result two cycles later.
    bus_if.req0_valid = 1'b1; bus_if.req0_x = 5'd3; bus_if.req0_y = 5'd4;
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    chk("t1_ready0", bus_if.req0_ready, 1);
    chk("t1_ready1", bus_if.req1_ready, 0);
    tick();
    bus_if.req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_rv_n+1", bus_if.resp_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_rv_n+2", bus_if.resp_valid, 1);
    chk("t1_sum", bus_if.resp_sum, 7);
    chk("t1_id", bus_if.resp_id, 0);
    tick();

    // Both valid continuously: alternating service starting with req0.
    do_reset();
    bus_if.req0_valid = 1'b1; bus_if.req0_x = 5'd1; bus_if.req0_y = 5'd1;
    bus_if.req1_valid = 1'b1; bus_if.req1_x = 5'd2; bus_if.req1_y = 5'd2;
    bus_if.resp_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(negedge clk);
      if (bus_if.resp_valid) begin
        ids[k]  = bus_if.resp_id;
        sums[k] = bus_if.resp_sum;
        k++;
      end
      tick();
    end
    idle_inputs();
    chk("t2_count", k, 4);
    if (k == 4) begin
      chk("t2_id0", ids[0], 0);  chk("t2_sum0", sums[0], 2);
      chk("t2_id1", ids[1], 1);  chk("t2_sum1", sums[1], 4);
      chk("t2_id2", ids[2], 0);  chk("t2_sum2", sums[2], 2);
      chk("t2_id3", ids[3], 1);  chk("t2_sum3", sums[3], 4);
    end
    tick();

    // Maximum operands from req1: carry out, no saturation.
    bus_if.req1_valid = 1'b1; bus_if.req1_x = 5'd31; bus_if.req1_y = 5'd31;
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    chk("t3_ready1", bus_if.req1_ready, 1);
    tick();
    bus_if.req1_valid = 1'b0;
    wait_rv(10, ok);
    chk("t3_timeout", ok, 1);
    chk("t3_sum", bus_if.resp_sum, 62);
    chk("t3_id", bus_if.resp_id, 1);
    tick();

    // Back-pressure: result must hold and no new request accepted.
    do_reset();
    bus_if.req0_valid = 1'b1; bus_if.req0_x = 5'd5;  bus_if.req0_y = 5'd6;
    bus_if.req1_valid = 1'b1; bus_if.req1_x = 5'd10; bus_if.req1_y = 5'd10;
    bus_if.resp_ready = 1'b0;
    wait_rv(10, ok);
    chk("t4_timeout", ok, 1);
    chk("t4_sum", bus_if.resp_sum, 11);
    chk("t4_id", bus_if.resp_id, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("t4_hold_rv", bus_if.resp_valid, 1);
      chk("t4_hold_sum", bus_if.resp_sum, 11);
      chk("t4_hold_id", bus_if.resp_id, 0);
      chk("t4_hold_ready0", bus_if.req0_ready, 0);
      chk("t4_hold_ready1", bus_if.req1_ready, 0);
    end
    tick();
    idle_inputs();
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    chk("t4_last_rv", bus_if.resp_valid, 1);
    tick();
    bus_if.resp_ready = 1'b0;
    @(negedge clk);
    chk("t4_busy_after", bus_if.busy, 0);
    tick();

    // Reset during CALC discards the operation.
    do_reset();
    bus_if.req0_valid = 1'b1; bus_if.req0_x = 5'd7; bus_if.req0_y = 5'd8;
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    chk("t5_ready0", bus_if.req0_ready, 1);
    tick();
    bus_if.req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy_rst", bus_if.busy, 0);
    tick();
    rst = 1'b0;
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_if.resp_valid) saw = 1;
      tick();
    end
    chk("t5_no_resp", saw, 0);
    bus_if.req0_valid = 1'b1; bus_if.req0_x = 5'd1; bus_if.req0_y = 5'd2;
    bus_if.req1_valid = 1'b1; bus_if.req1_x = 5'd3; bus_if.req1_y = 5'd3;
    @(negedge clk);
    chk("t5_next_ready0", bus_if.req0_ready, 1);
    chk("t5_next_ready1", bus_if.req1_ready, 0);
    tick();
    bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0;
    wait_rv(10, ok);
    chk("t5_timeout", ok, 1);
    chk("t5_sum", bus_if.resp_sum, 3);
    chk("t5_id", bus_if.resp_id, 0);
    tick();

    // req0 pulse while busy: ignored, pointer untouched.
    do_reset();
    bus_if.req1_valid = 1'b1; bus_if.req1_x = 5'd9; bus_if.req1_y = 5'd9;
    @(negedge clk);
    chk("t6_ready1", bus_if.req1_ready, 1);
    tick();
    bus_if.req1_valid = 1'b0;
    tick();
    bus_if.req0_valid = 1'b1; bus_if.req0_x = 5'd1; bus_if.req0_y = 5'd1;
    @(negedge clk);
    chk("t6_pulse_ready0", bus_if.req0_ready, 0);
    tick();
    bus_if.req0_valid = 1'b0;
    @(negedge clk);
    chk("t6_sum", bus_if.resp_sum, 18);
    chk("t6_id", bus_if.resp_id, 1);
    tick();
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    tick();
    bus_if.resp_ready = 1'b0;
    @(negedge clk);
    chk("t6_no_capture", bus_if.busy, 0);
    tick();
    bus_if.req0_valid = 1'b1; bus_if.req1_valid = 1'b1;
    @(negedge clk);
    chk("t6_ptr_ready0", bus_if.req0_ready, 1);
    tick();
    idle_inputs();
    bus_if.resp_ready = 1'b1;
    wait_rv(10, ok);
    chk("t6_timeout", ok, 1);
    tick();

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus_if.req0_valid = $urandom_range(0, 1);
      bus_if.req1_valid = $urandom_range(0, 1);
      bus_if.req0_x = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      bus_if.req0_y = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      bus_if.req1_x = 5'($urandom_range(0, 31));
      bus_if.req1_y = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      bus_if.resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    bus_if.resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
